// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions used by the init, ksa and prga blocks.
package arc4_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_RD,
    ST_LEN_WR,
    ST_RD_I,
    ST_WAIT_I,
    ST_WAIT_J,
    ST_WR_I,
    ST_WR_J,
    ST_RD_PAD,
    ST_WR_CT
  } prga_state_t;

endpackage

// File: rtl/prga_encrypt.sv
// ARC4 PRGA encryptor: reads a length-prefixed PT message, writes CT = PT ^ keystream.
// S must already hold the KSA permutation; all memories are external with 1-cycle reads.
module prga_encrypt
  import arc4_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] s_addr,
  input  logic [BYTE_W-1:0] s_rddata,
  output logic [BYTE_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [ADDR_W-1:0] pt_addr,
  input  logic [BYTE_W-1:0] pt_rddata,
  output logic [ADDR_W-1:0] ct_addr,
  output logic [BYTE_W-1:0] ct_wrdata,
  output logic              ct_wren,
  output prga_state_t       dbg_state
);

  // Handshake: a run starts on any cycle where rdy=1 and en=1; en is ignored while rdy=0.

  prga_state_t state_q, state_d;
  byte_t i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
  byte_t si_q, si_d, sj_q, sj_d, ptb_q, ptb_d;
  byte_t s_addr_b, pt_addr_b, ct_addr_b;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    ptb_d     = ptb_q;
    rdy       = 1'b0;
    s_addr_b  = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    pt_addr_b = '0;
    ct_addr_b = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_LEN_RD;
        end
      end
      ST_LEN_RD: begin
        pt_addr_b = '0;
        state_d   = ST_LEN_WR;
      end
      ST_LEN_WR: begin
        len_d     = pt_rddata;
        ct_addr_b = '0;
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
        state_d   = (pt_rddata == '0) ? ST_IDLE : ST_RD_I;
      end
      ST_RD_I: begin
        s_addr_b  = i_q + 8'd1;
        pt_addr_b = k_q + 8'd1;
        i_d       = i_q + 8'd1;
        state_d   = ST_WAIT_I;
      end
      ST_WAIT_I: begin
        // si is not registered yet, so the j+si address uses the live read data.
        si_d     = s_rddata;
        ptb_d    = pt_rddata;
        s_addr_b = j_q + s_rddata;
        state_d  = ST_WAIT_J;
      end
      ST_WAIT_J: begin
        sj_d    = s_rddata;
        j_d     = j_q + si_q;
        state_d = ST_WR_I;
      end
      ST_WR_I: begin
        s_addr_b = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
        state_d  = ST_WR_J;
      end
      ST_WR_J: begin
        s_addr_b = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = ST_RD_PAD;
      end
      ST_RD_PAD: begin
        s_addr_b = si_q + sj_q;
        state_d  = ST_WR_CT;
      end
      ST_WR_CT: begin
        ct_addr_b = k_q + 8'd1;
        ct_wrdata = s_rddata ^ ptb_q;
        ct_wren   = 1'b1;
        k_d       = k_q + 8'd1;
        state_d   = (k_q + 8'd1 == len_q) ? ST_IDLE : ST_RD_I;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset silences every output in the same cycle, so an aborted run writes nothing more.
    if (rst) begin
      rdy       = 1'b0;
      s_addr_b  = '0;
      s_wrdata  = '0;
      s_wren    = 1'b0;
      pt_addr_b = '0;
      ct_addr_b = '0;
      ct_wrdata = '0;
      ct_wren   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      ptb_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ptb_q   <= ptb_d;
    end
  end

  assign s_addr    = ADDR_W'(s_addr_b);
  assign pt_addr   = ADDR_W'(pt_addr_b);
  assign ct_addr   = ADDR_W'(ct_addr_b);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prga_encrypt.sv
// Directed bench for prga_encrypt: vector table on identity S plus multi-cycle
// sequences (held/pulsed en, mid-run reset, round trip, key/length sweep) vs an ARC4 model.
module tb_prga_encrypt;
  import arc4_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        rdy;
  logic [7:0]  s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata;
  logic [7:0]  ct_addr, ct_wrdata;
  logic        s_wren, ct_wren;
  prga_state_t dbg_state;

  logic [7:0]  s_mem [256];
  logic [7:0]  pt_mem[256];
  logic [7:0]  ct_mem[256];
  logic [7:0]  m_s   [256];
  logic [7:0]  m_pt  [256];
  logic [7:0]  saved [256];
  logic [15:0] exp_q[$];

  int total = 0;
  int bad = 0;
  int s_wr_cnt = 0;
  int ct_wr_cnt = 0;
  int excl_err = 0;

  typedef struct {
    int             len;
    logic [3:0][7:0] pt;
    logic [3:0][7:0] ct;
    int             cyc;
    logic [7:0]     s1, s2, s3;
  } vec_t;
  vec_t vecs[4];

  prga_encrypt #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
    .dbg_state(dbg_state)
  );

  // clock / memories
  always #5 clk = ~clk;

  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard: every CT write must match the head of exp_q
  always @(negedge clk) begin
    if (s_wren && ct_wren) excl_err++;
    if (!rst && s_wren) s_wr_cnt++;
    if (!rst && ct_wren) begin
      ct_wr_cnt++;
      if (exp_q.size() == 0) check("ct_unexpected", {ct_addr, ct_wrdata}, 16'hffff);
      else check("ct_write", {ct_addr, ct_wrdata}, exp_q.pop_front());
    end
  end

  // driver / model tasks
  task automatic model_ksa(input logic [23:0] key);
    logic [7:0] j, t, kb;
    for (int i = 0; i < 256; i++) m_s[i] = 8'(i);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0: kb = key[23:16];
        1: kb = key[15:8];
        default: kb = key[7:0];
      endcase
      j = j + m_s[i] + kb;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
    end
  endtask

  task automatic model_identity();
    for (int i = 0; i < 256; i++) m_s[i] = 8'(i);
  endtask

  task automatic model_enc();
    logic [7:0] i, j, t, len;
    len = m_pt[0];
    exp_q.push_back({8'h00, len});
    i = 0; j = 0;
    for (int k = 1; k <= int'(len); k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      t = m_s[i] + m_s[j];
      exp_q.push_back({8'(k), m_pt[k] ^ m_s[t]});
    end
  endtask

  task automatic load_mems();
    for (int i = 0; i < 256; i++) begin
      s_mem[i]  <= m_s[i];
      pt_mem[i] <= m_pt[i];
      ct_mem[i] <= 8'hee;
    end
    @(negedge clk);
  endtask

  task automatic rand_msg(input int len);
    m_pt[0] = 8'(len);
    for (int i = 1; i < 256; i++) m_pt[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic cmp_s(input string nm);
    int n = 0;
    for (int i = 0; i < 256; i++) if (s_mem[i] !== m_s[i]) n++;
    check(nm, n, 0);
  endtask

  task automatic run_msg(input string nm, input int exp_cyc, input bit pulse_en);
    int cyc;
    s_wr_cnt = 0;
    excl_err = 0;
    @(negedge clk);
    check({nm, "_rdy0"}, rdy, 1);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      en = (pulse_en && cyc == 8) ? 1'b1 : 1'b0;
    end while (!rdy && cyc < 3000);
    en = 1'b0;
    check({nm, "_cycles"}, cyc, exp_cyc);
    check({nm, "_qempty"}, exp_q.size(), 0);
    check({nm, "_excl"}, excl_err, 0);
  endtask

  initial begin
    // hand-computed vectors on identity S
    vecs[0] = '{0, 32'h0, 32'h0, 3, 8'd1, 8'd2, 8'd3};
    vecs[1] = '{1, 32'h0, {8'h00, 8'h00, 8'h02, 8'h00}, 10, 8'd1, 8'd2, 8'd3};
    vecs[2] = '{2, 32'h0, {8'h00, 8'h05, 8'h02, 8'h00}, 17, 8'd1, 8'd3, 8'd2};
    vecs[3] = '{3, {8'hff, 8'h0f, 8'ha0, 8'h00}, {8'hf8, 8'h0a, 8'ha2, 8'h00}, 24, 8'd1, 8'd3, 8'd5};

    // clock / reset
    model_identity();
    rand_msg(0);
    load_mems();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", rdy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_outs", {s_wren, ct_wren, s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata}, 0);
    rst = 1'b0;
    #1 check("rel_rdy", rdy, 1);

    // table-driven vectors
    for (int v = 0; v < 4; v++) begin
      model_identity();
      for (int i = 0; i < 256; i++) m_pt[i] = 8'h00;
      m_pt[0] = 8'(vecs[v].len);
      for (int k = 1; k < 4; k++) m_pt[k] = vecs[v].pt[k];
      load_mems();
      exp_q.push_back({8'h00, 8'(vecs[v].len)});
      for (int k = 1; k <= vecs[v].len; k++) exp_q.push_back({8'(k), vecs[v].ct[k]});
      run_msg($sformatf("vec%0d", v), vecs[v].cyc, 1'b0);
      check($sformatf("vec%0d_swr", v), s_wr_cnt, 2 * vecs[v].len);
      check($sformatf("vec%0d_ct0", v), ct_mem[0], 8'(vecs[v].len));
      check($sformatf("vec%0d_s", v), {s_mem[1], s_mem[2], s_mem[3]},
            {vecs[v].s1, vecs[v].s2, vecs[v].s3});
    end

    // en held high restarts right after completion
    begin
      int cyc;
      model_identity();
      for (int i = 0; i < 256; i++) m_pt[i] = 8'h00;
      m_pt[0] = 8'd1;
      load_mems();
      model_enc();
      model_enc();
      @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!rdy && cyc < 100);
      check("hold_cycles", cyc, 10);
      @(negedge clk);
      check("hold_restart", {rdy, dbg_state}, {1'b0, ST_LEN_RD});
      en = 1'b0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!rdy && cyc < 100);
      check("hold_cycles2", cyc, 9);
      check("hold_qempty", exp_q.size(), 0);
    end

    // en pulsed mid-run is ignored
    model_ksa(24'h5a3c11);
    rand_msg(30);
    load_mems();
    model_enc();
    run_msg("pulse", 3 + 7 * 30, 1'b1);
    cmp_s("pulse_s");

    // reset during byte 6 of a 20-byte message, then a fresh run
    begin
      int guard = 0;
      model_ksa(24'h0badf0);
      rand_msg(20);
      load_mems();
      model_enc();
      ct_wr_cnt = 0;
      @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #1 en = 1'b0;
      while (ct_wr_cnt < 6 && guard < 500) begin @(negedge clk); guard++; end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_quiet", {rdy, s_wren, ct_wren}, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_idle", {rdy, dbg_state}, {1'b1, ST_IDLE});
      check("abort_nowrite", ct_mem[6], 8'hee);
      exp_q.delete();
      model_ksa(24'h0badf0);
      load_mems();
      model_enc();
      run_msg("after_abort", 3 + 7 * 20, 1'b0);
      cmp_s("after_abort_s");
    end

    // round trip: encrypt, then run the CT back through with the same S
    begin
      int n = 0;
      model_ksa(24'h000018);
      rand_msg(64);
      for (int i = 0; i < 256; i++) saved[i] = m_pt[i];
      load_mems();
      model_enc();
      run_msg("rt_enc", 3 + 7 * 64, 1'b0);
      for (int i = 0; i < 256; i++) m_pt[i] = ct_mem[i];
      model_ksa(24'h000018);
      load_mems();
      model_enc();
      run_msg("rt_dec", 3 + 7 * 64, 1'b0);
      for (int i = 0; i <= 64; i++) if (ct_mem[i] !== saved[i]) n++;
      check("rt_recover", n, 0);
    end

    // key / length sweep, including the full 255-byte wrap case
    for (int r = 0; r < 4; r++) begin
      int len;
      len = (r == 0) ? 255 : $urandom_range(1, 254);
      model_ksa(24'($urandom()));
      rand_msg(len);
      load_mems();
      model_enc();
      run_msg($sformatf("sweep%0d", r), 3 + 7 * len, 1'b0);
      cmp_s($sformatf("sweep%0d_s", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
